// File: rtl/spi_target_regfile.sv
// SPI target with a small register file, all pins oversampled on CLK.
// Frame: {rnw, addr, data} MSB first; rnw=1 reads, rnw=0 writes.
module spi_target_regfile #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 24,
  parameter int NREGS  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              spi_sclk,
  input  logic              spi_csb,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdo_oe,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err,
  input  logic [ADDR_W-1:0] lcl_addr,
  output logic [DATA_W-1:0] lcl_data
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CMD_W   = 1 + ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int IDX_W   = $clog2(NREGS);

  localparam logic [CNT_W-1:0]  CMD_CNT   = CNT_W'(CMD_W);
  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_W);
  localparam logic [ADDR_W-1:0] NREGS_A   = ADDR_W'(NREGS);

  typedef enum logic [1:0] {IDLE, CMD, DATA, OVER} state_t;

  state_t state, state_nxt;

  logic [2:0] csb_p, sclk_p;
  logic [1:0] sdi_p;
  logic [1:0] vld;
  logic       armed;

  logic [FRAME_W-1:0] sr;
  logic [CNT_W-1:0]   bit_cnt;
  logic               over;
  logic               rnw_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  tx;
  logic               tx_loaded;
  logic [DATA_W-1:0]  regs [NREGS];

  logic csb_fall, csb_rise, sclk_rise, sclk_fall, sdi;
  logic in_frame, sclk_in_frame, start;
  logic [CNT_W-1:0]   cnt_inc, cnt_eff;
  logic [FRAME_W-1:0] sr_eff;
  logic               over_eff, frame_ok;
  logic [ADDR_W-1:0]  f_addr;
  logic [DATA_W-1:0]  f_data, rd_word;
  logic               commit_wr, commit_err;

  assign csb_fall  = csb_p[2] & ~csb_p[1];
  assign csb_rise  = ~csb_p[2] & csb_p[1];
  assign sclk_rise = ~sclk_p[2] & sclk_p[1];
  assign sclk_fall = sclk_p[2] & ~sclk_p[1];
  assign sdi       = sdi_p[1];

  assign in_frame      = (state != IDLE);
  assign start         = (state == IDLE) & csb_fall & armed;
  assign sclk_in_frame = sclk_rise & ((state == CMD) | (state == DATA));
  assign cnt_inc       = bit_cnt + 1'b1;
  assign cnt_eff       = sclk_in_frame ? cnt_inc : bit_cnt;
  assign sr_eff        = sclk_in_frame ? {sr[FRAME_W-2:0], sdi} : sr;
  assign over_eff      = over | (sclk_rise & (state == OVER));
  assign frame_ok      = (cnt_eff == FRAME_CNT) & ~over_eff;
  assign f_addr        = sr_eff[FRAME_W-2 -: ADDR_W];
  assign f_data        = sr_eff[DATA_W-1:0];

  // A trailing sclk_rise in the csb_rise cycle is already folded into *_eff.
  assign commit_wr  = csb_rise & in_frame & frame_ok
                    & ~sr_eff[FRAME_W-1] & (f_addr < NREGS_A);
  assign commit_err = csb_rise & in_frame & ~frame_ok;

  assign rd_word = (addr_q < NREGS_A) ? regs[addr_q[IDX_W-1:0]] : '0;
  assign spi_sdo = tx[DATA_W-1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      csb_p  <= 3'b111;
      sclk_p <= 3'b000;
      sdi_p  <= 2'b00;
      vld    <= 2'b00;
      armed  <= 1'b0;
    end else begin
      csb_p  <= {csb_p[1:0], spi_csb};
      sclk_p <= {sclk_p[1:0], spi_sclk};
      sdi_p  <= {sdi_p[0], spi_sdi};
      vld    <= {vld[0], 1'b1};
      // Only a real high-then-low csb after reset may open a frame.
      armed  <= armed | (vld[1] & csb_p[1]);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = CMD;
      CMD: begin
        if (csb_rise) state_nxt = IDLE;
        else if (sclk_rise && cnt_inc == CMD_CNT)
          state_nxt = DATA;
      end
      DATA: begin
        if (csb_rise) state_nxt = IDLE;
        else if (sclk_rise && cnt_inc == FRAME_CNT)
          state_nxt = OVER;
      end
      OVER: if (csb_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sr         <= '0;
      bit_cnt    <= '0;
      over       <= 1'b0;
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      tx         <= '0;
      tx_loaded  <= 1'b0;
      spi_sdo_oe <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_err  <= 1'b0;
      lcl_data   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= commit_wr;
      frame_err <= commit_err;
      if (commit_wr) begin
        regs[f_addr[IDX_W-1:0]] <= f_data;
        wr_addr <= f_addr;
        wr_data <= f_data;
      end
      lcl_data <= (lcl_addr < NREGS_A)
                ? regs[lcl_addr[IDX_W-1:0]] : '0;
      if (start) begin
        sr        <= '0;
        bit_cnt   <= '0;
        over      <= 1'b0;
        tx_loaded <= 1'b0;
      end
      if (sclk_in_frame) begin
        sr      <= sr_eff;
        bit_cnt <= cnt_inc;
      end
      if (state == CMD && sclk_rise && cnt_inc == CMD_CNT) begin
        rnw_q  <= sr_eff[CMD_W-1];
        addr_q <= sr_eff[ADDR_W-1:0];
      end
      if (state == OVER && sclk_rise) over <= 1'b1;
      if (state == DATA && sclk_fall && rnw_q) begin
        tx_loaded  <= 1'b1;
        spi_sdo_oe <= 1'b1;
        tx         <= tx_loaded ? (tx << 1) : rd_word;
      end
      if (in_frame && csb_rise) begin
        spi_sdo_oe <= 1'b0;
        tx         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_target_regfile.sv
// Bench for spi_target_regfile: directed frames plus random frames
// checked against a frame-level register model.
module tb_spi_target_regfile;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        spi_sclk, spi_csb, spi_sdi;
  logic        spi_sdo, spi_sdo_oe;
  logic        wr_strobe, frame_err;
  logic [6:0]  wr_addr, lcl_addr;
  logic [23:0] wr_data, lcl_data;

  spi_target_regfile dut (
    .CLK(CLK), .RST_N(RST_N),
    .spi_sclk(spi_sclk), .spi_csb(spi_csb),
    .spi_sdi(spi_sdi), .spi_sdo(spi_sdo),
    .spi_sdo_oe(spi_sdo_oe), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .lcl_addr(lcl_addr),
    .lcl_data(lcl_data)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad = 0;
  logic [23:0] mregs [16];
  logic [30:0] exp_q [$];
  int          exp_err = 0;
  bit          idle_chk = 0;
  logic [30:0] mon_e;
  logic [23:0] rx;

  function automatic logic [23:0] mread(input logic [6:0] a);
    return (a < 7'd16) ? mregs[a[3:0]] : 24'h0;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (wr_strobe === 1'b1) begin
      if (exp_q.size() == 0) chk("wr_spurious", wr_strobe, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", wr_addr, mon_e[30:24]);
        chk("wr_data", wr_data, mon_e[23:0]);
      end
    end
    if (frame_err === 1'b1) begin
      if (exp_err == 0) chk("err_spurious", frame_err, 0);
      else begin
        exp_err--;
        chk("err_pulse", frame_err, 1);
      end
    end
    if (idle_chk) chk("oe_idle", spi_sdo_oe, 0);
  end

  // One frame, MSB first; rst_at>=0 pulses RST_N after that rise.
  task automatic send(input logic [31:0] fr, input int nbits,
                      input int rst_at, output logic [23:0] got);
    logic [6:0] a;
    bit rd, full;
    a = fr[30:24];
    rd = fr[31];
    full = (nbits == 32);
    got = '0;
    idle_chk = 0;
    if (rst_at < 0) begin
      if (!full) exp_err++;
      else if (!rd && a < 7'd16) exp_q.push_back({a, fr[23:0]});
    end
    spi_csb = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_sdi = (i < 32) ? fr[31 - i] : 1'b0;
      #80;
      if (rst_at < 0) begin
        chk("sdo_oe", spi_sdo_oe, (rd && i >= 8) ? 1 : 0);
        if (rd && i >= 8 && i < 32) got = {got[22:0], spi_sdo};
      end
      spi_sclk = 1'b1;
      if (i == rst_at) begin
        RST_N = 1'b0;
        #30;
        RST_N = 1'b1;
        #50;
      end else #80;
      spi_sclk = 1'b0;
    end
    #80;
    spi_csb = 1'b1;
    spi_sdi = 1'b0;
    #250;
    if (rst_at >= 0) begin
      for (int k = 0; k < 16; k++) mregs[k] = '0;
    end else begin
      if (full && !rd && a < 7'd16) mregs[a[3:0]] = fr[23:0];
      if (full && rd) chk("rd_data", got, mread(a));
    end
    chk("wr_pending", exp_q.size(), 0);
    chk("err_pending", exp_err, 0);
    exp_q.delete();
    exp_err = 0;
    idle_chk = 1;
  endtask

  task automatic lcl_chk(input logic [6:0] a);
    lcl_addr = a;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("lcl_data", lcl_data, mread(a));
  endtask

  initial begin
    logic [31:0] fr;
    int kind, n;
    for (int k = 0; k < 16; k++) mregs[k] = '0;
    RST_N = 1'b0;
    spi_sclk = 1'b0;
    spi_csb = 1'b1;
    spi_sdi = 1'b0;
    lcl_addr = '0;
    #35;
    RST_N = 1'b1;
    #40;
    chk("rst_sdo", spi_sdo, 0);
    chk("rst_oe", spi_sdo_oe, 0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_lcl", lcl_data, 0);
    idle_chk = 1;

    send(32'h05A5A5A5, 32, -1, rx);
    lcl_chk(7'd5);
    chk("t1_lit", lcl_data, 24'hA5A5A5);

    send(32'h85000000, 32, -1, rx);
    chk("t2_lit", rx, 24'hA5A5A5);

    send(32'h05123456, 20, -1, rx);
    lcl_chk(7'd5);
    send(32'h03C0FFEE, 32, -1, rx);
    lcl_chk(7'd3);
    chk("t3_lit", lcl_data, 24'hC0FFEE);

    send(32'h7F123456, 32, -1, rx);
    send(32'hFF000000, 32, -1, rx);
    chk("t4_lit", rx, 24'h0);
    lcl_chk(7'h7F);

    send(32'h05000000, 33, -1, rx);
    lcl_chk(7'd5);
    chk("t5_lit", lcl_data, 24'hA5A5A5);

    send(32'h05777777, 32, 12, rx);
    for (int k = 0; k < 16; k++) lcl_chk(7'(k));
    send(32'h0A654321, 32, -1, rx);
    lcl_chk(7'd10);
    chk("t6_lit", lcl_data, 24'h654321);

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 4);
      fr = $urandom;
      n = 32;
      case (kind)
        0: fr[31:28] = 4'h0;
        1: fr[31] = 1'b0;
        2: fr[31:28] = 4'h8;
        3: n = $urandom_range(0, 31);
        default: n = $urandom_range(33, 34);
      endcase
      send(fr, n, -1, rx);
      lcl_chk(7'($urandom_range(0, 20)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
